id_ex_alu_issue: RTL

- ID/EX pipeline stage directly upstream of the 32-bit ALU.
- Captures decoded instruction fields and applies EX/MEM and MEM/WB operand forwarding.
- Decodes ALU control (alu_op plus funct) into the ALU 4-bit select code and holds registered operands/select for the ALU under a valid/ready handshake with stall and flush.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_control.sv | 36 +++
 rtl/id_ex_alu_issue.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings: select codes, main-control ALU classes and R-type funct codes.
// Consumed by the ID/EX issue stage, the ALU control decoder and the ALU itself.
package alu_pkg;

    localparam int unsigned SEL_W   = 4;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned FUNCT_W = 6;

    localparam logic [SEL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [SEL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [SEL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [SEL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [SEL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [SEL_W-1:0] ALU_NOR = 4'b1100;

    localparam logic [ALUOP_W-1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [ALUOP_W-1:0] ALU_OP_OR    = 2'b11;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;
    localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/alu_control.sv
// Combinational ALU control: main-control class plus funct -> 4-bit ALU select.
// Unknown R-type funct falls back to add and raises illegal.
module alu_control
    import alu_pkg::*;
(
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [SEL_W-1:0]   select,
    output logic               illegal
);

    always_comb begin
        select  = ALU_ADD;
        illegal = 1'b0;
        case (alu_op)
            ALU_OP_ADD: select = ALU_ADD;
            ALU_OP_SUB: select = ALU_SUB;
            ALU_OP_OR:  select = ALU_OR;
            default: begin
                case (funct)
                    FUNCT_ADD: select = ALU_ADD;
                    FUNCT_SUB: select = ALU_SUB;
                    FUNCT_AND: select = ALU_AND;
                    FUNCT_OR:  select = ALU_OR;
                    FUNCT_SLT: select = ALU_SLT;
                    FUNCT_NOR: select = ALU_NOR;
                    default: begin
                        select  = ALU_ADD;
                        illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX stage feeding the ALU: operand forwarding, ALU control decode and a
// single-entry valid/ready register with stall and flush.
module id_ex_alu_issue
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [REG_AW-1:0]  rs_addr,
    input  logic [REG_AW-1:0]  rt_addr,
    input  logic [DATA_W-1:0]  rs_data,
    input  logic [DATA_W-1:0]  rt_data,
    input  logic [DATA_W-1:0]  imm,
    input  logic               alu_src,
    input  logic [REG_AW-1:0]  dest_addr,
    input  logic               reg_write,
    input  logic               exm_wen,
    input  logic [REG_AW-1:0]  exm_addr,
    input  logic [DATA_W-1:0]  exm_data,
    input  logic               mwb_wen,
    input  logic [REG_AW-1:0]  mwb_addr,
    input  logic [DATA_W-1:0]  mwb_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [SEL_W-1:0]   alu_select,
    output logic [DATA_W-1:0]  store_data,
    output logic [REG_AW-1:0]  ex_dest_addr,
    output logic               ex_reg_write,
    output logic               illegal_op
);

    logic              r_valid;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [SEL_W-1:0]  r_select;
    logic [DATA_W-1:0] r_store;
    logic [REG_AW-1:0] r_dest;
    logic              r_reg_write;
    logic              r_illegal;

    logic              w_load;
    logic [DATA_W-1:0] w_rs_fwd;
    logic [DATA_W-1:0] w_rt_fwd;
    logic [SEL_W-1:0]  w_select;
    logic              w_illegal;

    alu_control u_alu_control (
        .alu_op  (alu_op),
        .funct   (funct),
        .select  (w_select),
        .illegal (w_illegal)
    );

    // Youngest producer (EX/MEM) wins; register 0 is never forwarded.
    always_comb begin
        w_rs_fwd = rs_data;
        w_rt_fwd = rt_data;
        if (exm_wen && (exm_addr == rs_addr) && (rs_addr != '0))
            w_rs_fwd = exm_data;
        else if (mwb_wen && (mwb_addr == rs_addr) && (rs_addr != '0))
            w_rs_fwd = mwb_data;
        if (exm_wen && (exm_addr == rt_addr) && (rt_addr != '0))
            w_rt_fwd = exm_data;
        else if (mwb_wen && (mwb_addr == rt_addr) && (rt_addr != '0))
            w_rt_fwd = mwb_data;
    end

    assign in_ready = !r_valid || out_ready;
    assign w_load   = in_valid && in_ready && !flush;

    // Flush beats load beats drain; a stall simply holds everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_select    <= '0;
            r_store     <= '0;
            r_dest      <= '0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_load) begin
            r_valid     <= 1'b1;
            r_alu_a     <= w_rs_fwd;
            r_alu_b     <= alu_src ? imm : w_rt_fwd;
            r_select    <= w_select;
            r_store     <= w_rt_fwd;
            r_dest      <= dest_addr;
            r_reg_write <= reg_write && !w_illegal;
            r_illegal   <= w_illegal;
        end else if (r_valid && out_ready) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end
    end

    assign out_valid    = r_valid;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_select   = r_select;
    assign store_data   = r_store;
    assign ex_dest_addr = r_dest;
    assign ex_reg_write = r_reg_write;
    assign illegal_op   = r_illegal;

endmodule
